// File: rtl/ppu_oam_writer_if.sv
// Bus bundle between the OAM writer and the CPU, DMA source, SPRAM port and sprite loader.
// Signal directions are named from the writer's point of view (i_ into it, o_ out of it).
interface ppu_oam_writer_if;
    logic        i_oamaddr_wr;
    logic        i_oamdata_wr;
    logic        i_oamdata_rd;
    logic [7:0]  i_cpu_data_in;
    logic [7:0]  o_cpu_data_out;
    logic        o_rd_valid;
    logic        i_dma_start;
    logic [7:0]  i_dma_page;
    logic [15:0] o_dma_bus_addr;
    logic        o_dma_bus_rd;
    logic [7:0]  i_dma_bus_data_in;
    logic        o_cpu_halt;
    logic        i_loader_busy;
    logic [7:0]  o_spram_addr;
    logic [7:0]  o_spram_data_out;
    logic        o_spram_we;
    logic [7:0]  i_spram_data_in;
    logic [7:0]  o_oam_addr;
    logic        o_wr_drop;

    modport slave (
        input  i_oamaddr_wr, i_oamdata_wr, i_oamdata_rd, i_cpu_data_in,
        input  i_dma_start, i_dma_page, i_dma_bus_data_in, i_loader_busy, i_spram_data_in,
        output o_cpu_data_out, o_rd_valid, o_dma_bus_addr, o_dma_bus_rd, o_cpu_halt,
        output o_spram_addr, o_spram_data_out, o_spram_we, o_oam_addr, o_wr_drop
    );

    modport master (
        output i_oamaddr_wr, i_oamdata_wr, i_oamdata_rd, i_cpu_data_in,
        output i_dma_start, i_dma_page, i_dma_bus_data_in, i_loader_busy, i_spram_data_in,
        input  o_cpu_data_out, o_rd_valid, o_dma_bus_addr, o_dma_bus_rd, o_cpu_halt,
        input  o_spram_addr, o_spram_data_out, o_spram_we, o_oam_addr, o_wr_drop
    );
endinterface

// File: rtl/ppu_oam_writer.sv
// PPU OAM write side: OAMADDR/OAMDATA CPU access, single-entry pending write buffer, 256-byte OAM DMA.
// Optional macro OAM_ATTR_MASK_EN clears attribute bits 4:2 on every write to byte 2 of a sprite.
module ppu_oam_writer (
    input  logic             clk,
    input  logic             rst,
    ppu_oam_writer_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

`ifdef OAM_ATTR_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic [2:0] r_state;
    logic [7:0] r_page;
    logic [7:0] r_cnt;
    logic       r_align_extra;
    logic       r_par;
    logic [7:0] r_oam_addr;
    logic       r_pend_valid;
    logic [7:0] r_pend_addr;
    logic [7:0] r_pend_data;
    logic [7:0] r_dma_buf;
    logic       r_rd_valid;
    logic       r_rd_blocked;
    logic       r_wr_drop;

    logic       w_cpu_ok;
    logic       w_addr_wr;
    logic       w_data_wr;
    logic       w_data_rd;
    logic       w_drain;
    logic       w_direct_wr;
    logic       w_capture;
    logic       w_drop;
    logic       w_dma_wr;
    logic [7:0] w_dma_data;

    function automatic logic [7:0] f_mask(input logic [7:0] addr, input logic [7:0] data);
        f_mask = (MASK_EN && addr[1:0] == 2'b10) ? (data & 8'hE3) : data;
    endfunction

    // CPU register accesses are only honoured while no DMA is running.
    assign w_cpu_ok    = (r_state == S_IDLE) && !rst;
    assign w_addr_wr   = w_cpu_ok && bus.i_oamaddr_wr;
    assign w_data_wr   = w_cpu_ok && bus.i_oamdata_wr && !bus.i_oamaddr_wr;
    assign w_data_rd   = w_cpu_ok && bus.i_oamdata_rd;
    assign w_drain     = r_pend_valid && !bus.i_loader_busy && !rst;
    assign w_direct_wr = w_data_wr && !bus.i_loader_busy && !w_drain;
    assign w_capture   = w_data_wr && (bus.i_loader_busy ? !r_pend_valid : w_drain);
    assign w_drop      = w_data_wr && bus.i_loader_busy && r_pend_valid;
    assign w_dma_wr    = !rst && !bus.i_loader_busy && (r_state == S_WRITE || r_state == S_HOLD);
    assign w_dma_data  = (r_state == S_WRITE) ? bus.i_dma_bus_data_in : r_dma_buf;

    // A draining pending entry owns the port, so it is older than any write arriving alongside it.
    always_comb begin
        bus.o_spram_we       = 1'b0;
        bus.o_spram_addr     = 8'h00;
        bus.o_spram_data_out = 8'h00;
        if (w_drain) begin
            bus.o_spram_we       = 1'b1;
            bus.o_spram_addr     = r_pend_addr;
            bus.o_spram_data_out = f_mask(r_pend_addr, r_pend_data);
        end else if (w_direct_wr) begin
            bus.o_spram_we       = 1'b1;
            bus.o_spram_addr     = r_oam_addr;
            bus.o_spram_data_out = f_mask(r_oam_addr, bus.i_cpu_data_in);
        end else if (w_dma_wr) begin
            bus.o_spram_we       = 1'b1;
            bus.o_spram_addr     = r_oam_addr;
            bus.o_spram_data_out = f_mask(r_oam_addr, w_dma_data);
        end else if (w_data_rd) begin
            bus.o_spram_addr     = r_oam_addr;
        end
    end

    assign bus.o_dma_bus_rd   = !rst && (r_state == S_READ);
    assign bus.o_dma_bus_addr = bus.o_dma_bus_rd ? {r_page, r_cnt} : 16'h0000;
    assign bus.o_cpu_halt     = !rst && (r_state != S_IDLE);
    assign bus.o_oam_addr     = r_oam_addr;
    assign bus.o_wr_drop      = r_wr_drop;
    assign bus.o_rd_valid     = r_rd_valid;
    assign bus.o_cpu_data_out = r_rd_valid ? (r_rd_blocked ? 8'hFF : bus.i_spram_data_in) : 8'h00;

    // A read whose request cycle lost the port to the loader or to a write returns all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_oam_addr   <= 8'h00;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 8'h00;
            r_pend_data  <= 8'h00;
            r_rd_valid   <= 1'b0;
            r_rd_blocked <= 1'b0;
            r_wr_drop    <= 1'b0;
        end else begin
            r_par        <= ~r_par;
            r_rd_valid   <= w_data_rd;
            r_rd_blocked <= bus.i_loader_busy || w_drain || w_direct_wr;
            if (w_drop)
                r_wr_drop <= 1'b1;
            if (w_capture) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= r_oam_addr;
                r_pend_data  <= bus.i_cpu_data_in;
            end else if (w_drain) begin
                r_pend_valid <= 1'b0;
            end
            if (w_addr_wr)
                r_oam_addr <= bus.i_cpu_data_in;
            else if (w_data_wr || w_dma_wr)
                r_oam_addr <= r_oam_addr + 8'd1;
        end
    end

    // DMA sequencer; the extra ALIGN cycle when par was 1 models the CPU's odd-cycle alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_page        <= 8'h00;
            r_cnt         <= 8'h00;
            r_align_extra <= 1'b0;
            r_dma_buf     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_dma_start) begin
                        r_page        <= bus.i_dma_page;
                        r_cnt         <= 8'h00;
                        r_align_extra <= r_par;
                        r_state       <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (r_align_extra)
                        r_align_extra <= 1'b0;
                    else if (!r_pend_valid)
                        r_state <= S_READ;
                end
                S_READ: r_state <= S_WRITE;
                S_WRITE, S_HOLD: begin
                    if (r_state == S_WRITE)
                        r_dma_buf <= bus.i_dma_bus_data_in;
                    if (bus.i_loader_busy) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= (r_cnt == 8'hFF) ? S_DONE : S_READ;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
